// File: rtl/rca32_and_or_locked.sv
// 32-bit ripple-carry adder locked with 64 AND/OR key gates; registered 33-bit sum.
// Two gates per slice: key[2i] gates the propagate term, key[2i+1] gates the carry out.

module key_gate #(
  parameter bit IS_AND = 1'b1
) (
  input  logic net,
  input  logic k,
  output logic y
);
  // AND gates are transparent at k=1, OR gates at k=0.
  if (IS_AND) begin : g_and
    assign y = net & k;
  end else begin : g_or
    assign y = net | k;
  end
endmodule

module rca32_and_or_locked #(
  parameter int WIDTH = 32,
  parameter int KEY_W = 2 * WIDTH
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [WIDTH-1:0] add1_i,
  input  logic [WIDTH-1:0] add2_i,
  input  logic [KEY_W-1:0] keyinput,
  output logic [WIDTH:0]   result_o
);

  localparam logic [63:0] CORRECT_KEY = 64'hA87E0E812FE200DE;

  logic [WIDTH-1:0] sum_bits;
  logic             carry_out;

  for (genvar i = 0; i < WIDTH; i++) begin : slice
    logic c_in;
    logic p;
    logic g;
    logic p_key;
    logic c_raw;
    logic c_out;

    // Carry is threaded slice to slice rather than through one shared vector.
    if (i == 0) begin : g_first
      assign c_in = 1'b0;
    end else begin : g_next
      assign c_in = slice[i-1].c_out;
    end

    assign p = add1_i[i] ^ add2_i[i];
    assign g = add1_i[i] & add2_i[i];

    (* keep_hierarchy = "yes" *)
    key_gate #(.IS_AND(CORRECT_KEY[2*i])) u_kg_prop (
      .net (p),
      .k   (keyinput[2*i]),
      .y   (p_key)
    );

    assign sum_bits[i] = p_key ^ c_in;
    assign c_raw       = g | (p_key & c_in);

    (* keep_hierarchy = "yes" *)
    key_gate #(.IS_AND(CORRECT_KEY[2*i+1])) u_kg_carry (
      .net (c_raw),
      .k   (keyinput[2*i+1]),
      .y   (c_out)
    );
  end

  assign carry_out = slice[WIDTH-1].c_out;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      result_o <= '0;
    end else begin
      result_o <= {carry_out, sum_bits};
    end
  end

endmodule

// File: tb/tb_rca32_and_or_locked.sv
// Self-checking bench for rca32_and_or_locked: directed vector table, back-to-back
// stream with mid-run reset, random sweeps against a+b and against a bit-level model.

module tb_rca32_and_or_locked;

  localparam logic [63:0] KC = 64'hA87E0E812FE200DE;

  logic        clk;
  logic        rst_n;
  logic [31:0] a;
  logic [31:0] b;
  logic [63:0] key;
  logic [32:0] result;

  int checks = 0;
  int errors = 0;

  rca32_and_or_locked dut (
    .clk_i    (clk),
    .rst_ni   (rst_n),
    .add1_i   (a),
    .add2_i   (b),
    .keyinput (key),
    .result_o (result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [63:0] key;
    logic [31:0] a;
    logic [31:0] b;
    logic [32:0] exp;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [32:0] got, input logic [32:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // Bit-level reference of the locked adder, written from the gate rules.
  function automatic logic [32:0] model(input logic [31:0] x, input logic [31:0] y,
                                        input logic [63:0] k);
    logic [63:0] ck;
    logic [32:0] r;
    logic c, p, g, cr;
    ck = KC;
    c  = 1'b0;
    r  = '0;
    for (int i = 0; i < 32; i++) begin
      p = x[i] ^ y[i];
      g = x[i] & y[i];
      p = ck[2*i] ? (p & k[2*i]) : (p | k[2*i]);
      r[i] = p ^ c;
      cr = g | (p & c);
      c = ck[2*i+1] ? (cr & k[2*i+1]) : (cr | k[2*i+1]);
    end
    r[32] = c;
    return r;
  endfunction

  // Drive inputs just after an edge, then sample just after the next edge.
  task automatic apply(input logic [63:0] k, input logic [31:0] x, input logic [31:0] y);
    key = k;
    a   = x;
    b   = y;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [31:0] ra, rb;
    logic [63:0] rk;
    logic [32:0] exp_q;

    vecs.push_back('{"ck_1p1",       KC,                    32'h00000001, 32'h00000001, 33'h000000002});
    vecs.push_back('{"ck_max_p1",    KC,                    32'hFFFFFFFF, 32'h00000001, 33'h100000000});
    vecs.push_back('{"ck_max_max",   KC,                    32'hFFFFFFFF, 32'hFFFFFFFF, 33'h1FFFFFFFE});
    vecs.push_back('{"ck_zero",      KC,                    32'h00000000, 32'h00000000, 33'h000000000});
    vecs.push_back('{"ck_mix",       KC,                    32'h12345678, 32'h87654321, 33'h099999999});
    vecs.push_back('{"ck_msb_msb",   KC,                    32'h80000000, 32'h80000000, 33'h100000000});
    vecs.push_back('{"k1_wrong",     64'hA87E0E812FE200DC,  32'h00000001, 32'h00000001, 33'h000000000});
    vecs.push_back('{"k1_ref",       KC,                    32'h00000001, 32'h00000001, 33'h000000002});
    vecs.push_back('{"k0_wrong",     64'hA87E0E812FE200DF,  32'h00000000, 32'h00000000, 33'h000000001});
    vecs.push_back('{"k61_wrong",    64'h887E0E812FE200DE,  32'h40000000, 32'h40000000, 33'h000000000});
    vecs.push_back('{"k61_ref",      KC,                    32'h40000000, 32'h40000000, 33'h080000000});

    // Reset for two edges with arbitrary inputs.
    rst_n = 1'b0;
    key   = 64'hFFFF0000FFFF0000;
    a     = 32'hDEADBEEF;
    b     = 32'hCAFEF00D;
    @(posedge clk);
    @(posedge clk);
    #1;
    check("reset", result, 33'h0);

    rst_n = 1'b1;
    apply(KC, 32'h00000001, 32'h00000001);
    check("post_reset_1p1", result, 33'h000000002);

    foreach (vecs[i]) begin
      apply(vecs[i].key, vecs[i].a, vecs[i].b);
      check(vecs[i].name, result, vecs[i].exp);
    end

    // Back-to-back stream with a one-edge reset in the middle.
    for (int i = 0; i < 12; i++) begin
      ra = 32'h11111111 * (i + 1);
      rb = 32'hF0000000 + i;
      rst_n = (i == 6) ? 1'b0 : 1'b1;
      apply(KC, ra, rb);
      exp_q = (i == 6) ? 33'h0 : ({1'b0, ra} + {1'b0, rb});
      check((i == 6) ? "stream_reset" : "stream", result, exp_q);
    end
    rst_n = 1'b1;

    for (int i = 0; i < 10000; i++) begin
      ra = $urandom;
      rb = $urandom;
      apply(KC, ra, rb);
      check("rand_ck", result, {1'b0, ra} + {1'b0, rb});
    end

    // Random wrong keys: mostly single-bit flips, some fully random.
    for (int i = 0; i < 400; i++) begin
      ra = $urandom;
      rb = $urandom;
      if (i % 4 == 3) rk = {$urandom, $urandom};
      else            rk = KC ^ (64'h1 << $urandom_range(63, 0));
      apply(rk, ra, rb);
      check("rand_key", result, model(ra, rb, rk));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
